// File: rtl/div_pkg.sv
// Shared types and constants for the signed 32-bit multi-cycle divider.
package div_pkg;

    localparam int WIDTH_C = 32;
    localparam int COUNT_W = 5;
    localparam logic [WIDTH_C-1:0] DIV0_QUO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left and subtract the divisor when it fits.
module div_step
    import div_pkg::*;
(
    input  logic [WIDTH_C-1:0] rem,
    input  logic [WIDTH_C-1:0] quo,
    input  logic [WIDTH_C-1:0] divisor,
    output logic [WIDTH_C-1:0] rem_next,
    output logic [WIDTH_C-1:0] quo_next
);

    logic [WIDTH_C:0] rem_sh_s;
    logic [WIDTH_C:0] trial_s;

    assign rem_sh_s = {rem, quo[WIDTH_C-1]};
    assign trial_s  = rem_sh_s - {1'b0, divisor};

    // Keep the trial difference only when it did not borrow.
    always_comb begin
        rem_next = rem_sh_s[WIDTH_C-1:0];
        quo_next = {quo[WIDTH_C-2:0], 1'b0};
        if (!trial_s[WIDTH_C]) begin
            rem_next = trial_s[WIDTH_C-1:0];
            quo_next = {quo[WIDTH_C-2:0], 1'b1};
        end else begin
            rem_next = rem_sh_s[WIDTH_C-1:0];
            quo_next = {quo[WIDTH_C-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/neg_32.sv
// Combinational two's complement negator shared with the datapath negate path.
module neg_32 (
    input  logic [31:0] a,
    output logic [31:0] z
);

    assign z = ~a + 32'd1;

endmodule

// File: rtl/div_32.sv
// Signed 32-bit restoring divider: magnitudes in, one step per clock, signs applied on exit.
module div_32
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] rA,
    input  logic [WIDTH-1:0] rB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] rZ_lo,
    output logic [WIDTH-1:0] rZ_hi
);

    state_t               state_r;
    state_t               state_next_s;
    logic [WIDTH_C-1:0]   quo_r;
    logic [WIDTH_C-1:0]   rem_r;
    logic [WIDTH_C-1:0]   dvs_r;
    logic [COUNT_W-1:0]   count_r;
    logic                 sign_q_r;
    logic                 sign_r_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 div_zero_r;
    logic [WIDTH_C-1:0]   lo_r;
    logic [WIDTH_C-1:0]   hi_r;

    logic [WIDTH_C-1:0]   neg_q_s;
    logic [WIDTH_C-1:0]   neg_b_in_s;
    logic [WIDTH_C-1:0]   neg_b_s;
    logic [WIDTH_C-1:0]   rem_next_s;
    logic [WIDTH_C-1:0]   quo_next_s;

    // Second negator serves the divisor during PREP and the remainder during FIX.
    assign neg_b_in_s = (state_r == PREP) ? dvs_r : rem_r;

    neg_32 u_neg_q (
        .a (quo_r),
        .z (neg_q_s)
    );

    neg_32 u_neg_b (
        .a (neg_b_in_s),
        .z (neg_b_s)
    );

    div_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_next_s),
        .quo_next (quo_next_s)
    );

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = PREP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PREP: begin
                if (dvs_r == 32'd0) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ITER;
                end
            end
            ITER: begin
                if (count_r == 5'd0) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = ITER;
                end
            end
            FIX:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand, iteration and result registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            quo_r      <= 32'd0;
            rem_r      <= 32'd0;
            dvs_r      <= 32'd0;
            count_r    <= 5'd0;
            sign_q_r   <= 1'b0;
            sign_r_r   <= 1'b0;
            div_zero_r <= 1'b0;
            lo_r       <= 32'd0;
            hi_r       <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        quo_r    <= rA;
                        dvs_r    <= rB;
                        sign_q_r <= rA[WIDTH_C-1] ^ rB[WIDTH_C-1];
                        sign_r_r <= rA[WIDTH_C-1];
                    end
                end
                PREP: begin
                    rem_r   <= 32'd0;
                    count_r <= {COUNT_W{1'b1}};
                    // quo_r still holds the raw dividend here, which is the div-by-zero remainder.
                    if (dvs_r == 32'd0) begin
                        lo_r       <= DIV0_QUO;
                        hi_r       <= quo_r;
                        div_zero_r <= 1'b1;
                    end else begin
                        quo_r <= quo_r[WIDTH_C-1] ? neg_q_s : quo_r;
                        dvs_r <= dvs_r[WIDTH_C-1] ? neg_b_s : dvs_r;
                    end
                end
                ITER: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    count_r <= count_r - 5'd1;
                end
                FIX: begin
                    lo_r       <= sign_q_r ? neg_q_s : quo_r;
                    hi_r       <= sign_r_r ? neg_b_s : rem_r;
                    div_zero_r <= 1'b0;
                end
                DONE: begin
                    count_r <= count_r;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign rZ_lo    = lo_r;
    assign rZ_hi    = hi_r;

endmodule

// File: tb/tb_div_32.sv
// Self-checking bench for div_32: vector table plus scoreboard, with busy and reset corner sequences.
module tb_div_32;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] rA;
    logic [31:0] rB;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] rZ_lo;
    logic [31:0] rZ_hi;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prev_q;
    logic [31:0] prev_r;
    logic        prev_dz;

    div_32 dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .rA       (rA),
        .rB       (rB),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .rZ_lo    (rZ_lo),
        .rZ_hi    (rZ_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        sa   = a;
        sb_v = b;
        dz   = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb_v;
            r = sa % sb_v;
        end
    endtask

    // inj_at > 0 pulses start with 1/1 so that it is sampled at edge E<inj_at>.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                          input logic [31:0] r, input logic dz, input int lat, input int inj_at);
        exp_t e;
        int   n;
        @(negedge clk);
        clr   = 1'b0;
        rA    = a;
        rB    = b;
        start = 1'b1;
        e.q = q; e.r = r; e.dz = dz; e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        rA    = $urandom;
        rB    = $urandom;
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("hold_lo", rZ_lo, prev_q);
        check("hold_hi", rZ_hi, prev_r);
        check("hold_dz", {31'd0, div_zero}, {31'd0, prev_dz});
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (inj_at > 0 && n == inj_at - 1) begin
                start = 1'b1;
                rA    = 32'd1;
                rB    = 32'd1;
            end else if (inj_at > 0 && n == inj_at) begin
                start = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=%0d exp=%0d", n, lat);
        end
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("busy_at_done", {31'd0, busy}, 32'd1);
        check("quotient", rZ_lo, e.q);
        check("remainder", rZ_hi, e.r);
        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        prev_q  = e.q;
        prev_r  = e.r;
        prev_dz = e.dz;
        @(posedge clk);
        #1;
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        vec_t        vecs[12];
        logic [31:0] ra, rb, mq, mr;
        logic        mdz;
        int          extra;

        checks   = 0;
        failures = 0;
        prev_q   = 32'd0;
        prev_r   = 32'd0;
        prev_dz  = 1'b0;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
        vecs[1]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 34};
        vecs[2]  = '{32'd7,          32'hFFFF_FF9C,  32'd0,          32'd7,          1'b0, 34};
        vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34};
        vecs[4]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
        vecs[5]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
        vecs[6]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34};
        vecs[7]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 34};
        vecs[8]  = '{32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1};
        vecs[9]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 34};
        vecs[10] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0, 34};
        vecs[11] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0, 34};

        clr   = 1'b1;
        start = 1'b0;
        rA    = 32'd0;
        rB    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        check("rst_lo", rZ_lo, 32'd0);
        check("rst_hi", rZ_hi, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, 0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            model(ra, rb, mq, mr, mdz);
            run_op(ra, rb, mq, mr, mdz, mdz ? 1 : 34, 0);
        end

        // Start pulsed at E10 while busy must be dropped, not queued.
        run_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34, 10);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("no_queued_op", extra, 32'd0);

        // Abort mid-operation with clr between E19 and E20.
        @(negedge clk);
        rA    = 32'd1000;
        rB    = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dz", {31'd0, div_zero}, 32'd0);
        check("abort_lo", rZ_lo, 32'd0);
        check("abort_hi", rZ_hi, 32'd0);
        prev_q  = 32'd0;
        prev_r  = 32'd0;
        prev_dz = 1'b0;
        run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
